// File: rtl/pc_pkg.sv
// pc_pkg: shared types for the program-counter unit
package pc_pkg;
  typedef enum logic [1:0] {BOOT, RUN, HALT} pc_state_t;
  typedef enum logic [2:0] {SEL_HOLD, SEL_SEQ, SEL_TARGET, SEL_TRAP, SEL_EPC} pc_sel_t;
endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: control inputs and fetch-side outputs of the program-counter unit
interface pc_unit_if #(parameter int XLEN = 32);
  logic            stall;
  logic            finish_flag;
  logic            br_taken;
  logic [XLEN-1:0] br_target;
  logic            trap_req;
  logic            trap_ret;
  logic [XLEN-1:0] pc_reg;
  logic            pc_valid;
  logic [XLEN-1:0] epc;
  logic            halted;
  logic            misaligned;
  modport master (
    output stall, finish_flag, br_taken, br_target, trap_req, trap_ret,
    input  pc_reg, pc_valid, epc, halted, misaligned
  );
  modport slave (
    input  stall, finish_flag, br_taken, br_target, trap_req, trap_ret,
    output pc_reg, pc_valid, epc, halted, misaligned
  );
endinterface

// File: rtl/pc_next_sel.sv
// pc_next_sel: priority decode of control inputs into next-PC select and epc/misaligned enables
module pc_next_sel
  import pc_pkg::*;
(
  input  pc_state_t state,
  input  logic      stall,
  input  logic      finish_flag,
  input  logic      br_taken,
  input  logic      trap_req,
  input  logic      trap_ret,
  input  logic      tgt_misaligned,
  output pc_sel_t   sel,
  output logic      epc_load,
  output logic      mis_set
);
  logic act;
  // act: RUN and not finishing, so exactly one of rules 2..7 applies
  assign act      = (state == RUN) && !finish_flag;
  assign mis_set  = act && !trap_req && br_taken && tgt_misaligned;
  assign epc_load = (act && trap_req) || mis_set;
  assign sel      = !act     ? SEL_HOLD   :
                    epc_load ? SEL_TRAP   :
                    trap_ret ? SEL_EPC    :
                    br_taken ? SEL_TARGET :
                    stall    ? SEL_HOLD   : SEL_SEQ;
endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with step advance, branches, traps, trap return, stall and sticky halt
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter int              STEP         = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
  input logic       clk,
  input logic       reset,
  pc_unit_if.slave  bus
);
  pc_state_t       state, state_nxt;
  pc_sel_t         sel;
  logic [XLEN-1:0] pc, pc_nxt, epc;
  logic            valid, halted, mis, epc_load, mis_set, tgt_mis;
  // STEP is a power of two, so STEP-1 masks the low bits that must be zero
  assign tgt_mis = |(bus.br_target & XLEN'(STEP - 1));
  pc_next_sel u_sel (
    .state          (state),
    .stall          (bus.stall),
    .finish_flag    (bus.finish_flag),
    .br_taken       (bus.br_taken),
    .trap_req       (bus.trap_req),
    .trap_ret       (bus.trap_ret),
    .tgt_misaligned (tgt_mis),
    .sel            (sel),
    .epc_load       (epc_load),
    .mis_set        (mis_set)
  );
  assign pc_nxt = sel == SEL_SEQ    ? pc + XLEN'(STEP) :
                  sel == SEL_TARGET ? bus.br_target    :
                  sel == SEL_TRAP   ? TRAP_VECTOR      :
                  sel == SEL_EPC    ? epc              : pc;
  assign state_nxt = state == BOOT                     ? RUN  :
                     (state == RUN && bus.finish_flag) ? HALT : state;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= BOOT;
      pc     <= RESET_VECTOR;
      epc    <= '0;
      valid  <= 1'b0;
      halted <= 1'b0;
      mis    <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      epc    <= epc_load ? pc : epc;
      valid  <= state_nxt == RUN;
      halted <= state_nxt == HALT;
      mis    <= mis_set;
    end
  end
  assign bus.pc_reg     = pc;
  assign bus.pc_valid   = valid;
  assign bus.epc        = epc;
  assign bus.halted     = halted;
  assign bus.misaligned = mis;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: STEP=4 and STEP=1 units driven in lockstep, checked against a rule-level model
module tb_pc_unit;
  logic        clk = 1'b0, reset = 1'b1;
  logic        stall = 0, fin = 0, br = 0, tr = 0, tret = 0;
  logic [31:0] tgt = '0;
  pc_unit_if #(.XLEN(32)) b0 ();
  pc_unit_if #(.XLEN(32)) b1 ();
  assign b0.stall = stall;  assign b0.finish_flag = fin;  assign b0.br_taken = br;
  assign b0.br_target = tgt; assign b0.trap_req = tr;   assign b0.trap_ret = tret;
  assign b1.stall = stall;  assign b1.finish_flag = fin;  assign b1.br_taken = br;
  assign b1.br_target = tgt; assign b1.trap_req = tr;   assign b1.trap_ret = tret;
  pc_unit #(.XLEN(32), .STEP(4)) d0 (.clk(clk), .reset(reset), .bus(b0.slave));
  pc_unit #(.XLEN(32), .STEP(1)) d1 (.clk(clk), .reset(reset), .bus(b1.slave));
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  logic [31:0] m_pc [2];
  logic [31:0] m_epc [2];
  logic        m_mis [2];
  int          m_mode [2];
  int unsigned stp [2] = '{4, 1};
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", n, a, e, $time);
    end
  endtask
  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 32'h0; m_epc[k] = 32'h0; m_mis[k] = 1'b0; m_mode[k] = 0;
    end
  endtask
  task automatic m_edge();
    for (int k = 0; k < 2; k++) begin
      m_mis[k] = 1'b0;
      if (m_mode[k] == 0) m_mode[k] = 1;
      else if (m_mode[k] == 1) begin
        if (fin) m_mode[k] = 2;
        else if (tr) begin m_epc[k] = m_pc[k]; m_pc[k] = 32'h100; end
        else if (br && (tgt % stp[k]) != 0) begin
          m_epc[k] = m_pc[k]; m_pc[k] = 32'h100; m_mis[k] = 1'b1;
        end
        else if (tret) m_pc[k] = m_epc[k];
        else if (br) m_pc[k] = tgt;
        else if (!stall) m_pc[k] = m_pc[k] + stp[k];
      end
    end
  endtask
  task automatic cmp_one(int k, logic [31:0] pc, logic v, logic [31:0] e, logic h, logic mi);
    chk($sformatf("pc%0d", k), pc, m_pc[k]);
    chk($sformatf("valid%0d", k), 32'(v), 32'(m_mode[k] == 1));
    chk($sformatf("epc%0d", k), e, m_epc[k]);
    chk($sformatf("halted%0d", k), 32'(h), 32'(m_mode[k] == 2));
    chk($sformatf("mis%0d", k), 32'(mi), 32'(m_mis[k]));
  endtask
  task automatic compare_all();
    cmp_one(0, b0.pc_reg, b0.pc_valid, b0.epc, b0.halted, b0.misaligned);
    cmp_one(1, b1.pc_reg, b1.pc_valid, b1.epc, b1.halted, b1.misaligned);
  endtask
  task automatic cyc();
    @(posedge clk);
    if (reset) m_reset(); else m_edge();
    #1 compare_all();
  endtask
  task automatic drive(bit s, bit f, bit b, logic [31:0] t, bit q, bit r);
    stall = s; fin = f; br = b; tgt = t; tr = q; tret = r;
  endtask
  task automatic async_reset();
    #3 reset = 1'b1;
    #1 m_reset();
    compare_all();
    chk("arst_pc", b0.pc_reg, 32'h0);
    chk("arst_halted", 32'(b0.halted), 32'h0);
    cyc();
    reset = 1'b0;
  endtask
  initial begin
    #1 m_reset();
    compare_all();
    chk("rst_valid", 32'(b0.pc_valid), 32'h0);
    cyc(); cyc();
    reset = 1'b0;
    cyc(); chk("boot_pc", b0.pc_reg, 32'h0); chk("boot_valid", 32'(b0.pc_valid), 32'h1);
    cyc(); chk("seq_pc4", b0.pc_reg, 32'h4);
    cyc(); chk("seq_pc8", b0.pc_reg, 32'h8);
    cyc(); chk("seq_pc12", b0.pc_reg, 32'hC);
    drive(0, 0, 1, 32'h20, 0, 0); cyc(); chk("br20", b0.pc_reg, 32'h20);
    drive(1, 0, 1, 32'h80, 0, 0); cyc(); chk("br_over_stall", b0.pc_reg, 32'h80);
    drive(1, 0, 0, 32'h0, 0, 0); cyc(); cyc(); chk("stall_hold", b0.pc_reg, 32'h80);
    drive(0, 0, 1, 32'h40, 0, 0); cyc();
    drive(0, 0, 0, 32'h0, 1, 0); cyc();
    chk("trap_pc", b0.pc_reg, 32'h100); chk("trap_epc", b0.epc, 32'h40);
    drive(0, 0, 0, 32'h0, 0, 0); cyc(); cyc();
    drive(0, 0, 0, 32'h0, 0, 1); cyc(); chk("tret_pc", b0.pc_reg, 32'h40);
    drive(0, 0, 0, 32'h0, 1, 1); cyc();
    chk("trap_wins_pc", b0.pc_reg, 32'h100); chk("trap_wins_epc", b0.epc, 32'h40);
    drive(0, 0, 1, 32'h10, 0, 0); cyc();
    drive(0, 0, 1, 32'h82, 0, 0); cyc();
    chk("mis_pc", b0.pc_reg, 32'h100); chk("mis_epc", b0.epc, 32'h10);
    chk("mis_flag", 32'(b0.misaligned), 32'h1);
    chk("step1_pc", b1.pc_reg, 32'h82); chk("step1_mis", 32'(b1.misaligned), 32'h0);
    drive(0, 0, 0, 32'h0, 0, 0); cyc(); chk("mis_pulse", 32'(b0.misaligned), 32'h0);
    drive(0, 0, 1, 32'hFFFF_FFFC, 0, 0); cyc();
    drive(0, 0, 0, 32'h0, 0, 0); cyc(); chk("wrap_pc", b0.pc_reg, 32'h0);
    drive(0, 0, 1, 32'h30, 0, 0); cyc();
    drive(0, 1, 0, 32'h0, 0, 0); cyc();
    chk("halt_pc", b0.pc_reg, 32'h30); chk("halt_flag", 32'(b0.halted), 32'h1);
    chk("halt_valid", 32'(b0.pc_valid), 32'h0);
    drive(0, 0, 1, 32'h80, 1, 0); cyc(); cyc(); chk("halt_sticky", b0.pc_reg, 32'h30);
    async_reset();
    drive(0, 0, 0, 32'h0, 0, 0); cyc(); chk("reboot_valid", 32'(b0.pc_valid), 32'h1);
    cyc(); chk("reboot_pc", b0.pc_reg, 32'h4);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(3) != 0) t = t & ~32'h3;
      drive($urandom_range(2) == 0, $urandom_range(150) == 0, $urandom_range(3) == 0, t,
            $urandom_range(7) == 0, $urandom_range(7) == 0);
      if ($urandom_range(200) == 0) async_reset();
      else cyc();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
